// File: rtl/fmc_stream_ctrl.sv
// FMC-side stream controller: synchronises the async FMC strobes, owns CTRL/STAT/THR,
// and keeps a one-word prefetch of the sample FIFO so DATA reads are stable for the whole nOE strobe.
module fmc_stream_ctrl #(
  parameter int         FIFO_AW   = 10,
  parameter logic [3:0] ADDR_CTRL = 4'h4,
  parameter logic [3:0] ADDR_STAT = 4'h5,
  parameter logic [3:0] ADDR_THR  = 4'h6,
  parameter logic [3:0] ADDR_DATA = 4'h8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [15:0]        i_fmc_addr,
  input  logic [31:0]        i_fmc_data_in,
  input  logic               i_fmc_ne,
  input  logic               i_fmc_noe,
  input  logic               i_fmc_nwe,
  output logic [31:0]        o_rd_data,
  input  logic [31:0]        i_fifo_dout,
  input  logic               i_fifo_empty,
  input  logic [FIFO_AW-1:0] i_fifo_usedw,
  output logic               o_fifo_rd_en,
  output logic               o_fifo_sclr,
  output logic               o_stream_en,
  output logic               o_irq
);

  localparam logic [31:0] NO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_ne_sync;
  logic [1:0]         r_noe_sync;
  logic [1:0]         r_nwe_sync;
  logic               r_ne_d;
  logic               r_noe_d;
  logic               r_nwe_d;
  logic [3:0]         r_addr;
  logic [31:0]        r_wdata;
  logic               r_stream_en;
  logic               r_irq_en;
  logic [FIFO_AW:0]   r_thr;
  logic [7:0]         r_underrun;
  logic [31:0]        r_pf_data;
  logic               r_irq;
  logic               w_wr_active;
  logic               w_rd_active;
  logic               w_wr_commit;
  logic               w_rd_done;
  logic               w_ctrl_wr;
  logic               w_thr_wr;
  logic               w_flush;
  logic               w_data_rd;
  logic               w_pf_valid;
  logic [31:0]        w_stat;
  logic               w_unused;

  // Synchronisers idle high so leaving reset never looks like a completed strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ne_sync  <= 2'b11;
      r_noe_sync <= 2'b11;
      r_nwe_sync <= 2'b11;
      r_ne_d     <= 1'b1;
      r_noe_d    <= 1'b1;
      r_nwe_d    <= 1'b1;
    end else begin
      r_ne_sync  <= {r_ne_sync[0], i_fmc_ne};
      r_noe_sync <= {r_noe_sync[0], i_fmc_noe};
      r_nwe_sync <= {r_nwe_sync[0], i_fmc_nwe};
      r_ne_d     <= r_ne_sync[1];
      r_noe_d    <= r_noe_sync[1];
      r_nwe_d    <= r_nwe_sync[1];
    end
  end

  assign w_wr_active = ~r_ne_sync[1] & ~r_nwe_sync[1];
  assign w_rd_active = ~r_ne_sync[1] & ~r_noe_sync[1];
  assign w_wr_commit = r_nwe_sync[1] & ~r_nwe_d & ~r_ne_d;
  assign w_rd_done   = r_noe_sync[1] & ~r_noe_d & ~r_ne_d;

  // Address/data capture; the values held at strobe release are the ones committed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr  <= 4'd0;
      r_wdata <= 32'd0;
    end else if (w_wr_active) begin
      r_addr  <= i_fmc_addr[3:0];
      r_wdata <= i_fmc_data_in;
    end else if (w_rd_active) begin
      r_addr  <= i_fmc_addr[3:0];
    end
  end

  assign w_ctrl_wr  = w_wr_commit && (r_addr == ADDR_CTRL);
  assign w_thr_wr   = w_wr_commit && (r_addr == ADDR_THR);
  assign w_flush    = w_ctrl_wr && r_wdata[1];
  assign w_data_rd  = w_rd_done && (r_addr == ADDR_DATA);
  assign w_pf_valid = (r_state == S_FULL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Fetch is held off while a read strobe is active so DATA cannot change under it.
  always_comb begin
    w_next = r_state;
    if (w_flush) begin
      w_next = S_FLUSH;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (r_stream_en && !i_fifo_empty && !w_rd_active) begin
            w_next = S_FETCH;
          end else begin
            w_next = S_EMPTY;
          end
        end
        S_FETCH: w_next = S_FULL;
        S_FULL: begin
          if (w_data_rd) begin
            w_next = S_EMPTY;
          end else begin
            w_next = S_FULL;
          end
        end
        S_FLUSH: w_next = S_EMPTY;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    if (i_reset) begin
      o_fifo_rd_en = 1'b0;
      o_fifo_sclr  = 1'b0;
    end else begin
      o_fifo_rd_en = (r_state == S_EMPTY) && (w_next == S_FETCH);
      o_fifo_sclr  = (r_state == S_FLUSH);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pf_data <= 32'd0;
    end else if (r_state == S_FETCH && !w_flush) begin
      r_pf_data <= i_fifo_dout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stream_en <= 1'b0;
      r_irq_en    <= 1'b0;
      r_thr       <= '0;
      r_underrun  <= 8'd0;
      r_irq       <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_stream_en <= r_wdata[0];
        r_irq_en    <= r_wdata[2];
      end
      if (w_thr_wr) begin
        r_thr <= r_wdata[FIFO_AW:0];
      end
      if (w_flush) begin
        r_underrun <= 8'd0;
      end else if (w_data_rd && !w_pf_valid && (r_underrun != 8'hFF)) begin
        r_underrun <= r_underrun + 8'd1;
      end
      r_irq <= r_irq_en && ({1'b0, i_fifo_usedw} >= r_thr);
    end
  end

  always_comb begin
    w_stat                 = 32'd0;
    w_stat[FIFO_AW-1:0]    = i_fifo_usedw;
    w_stat[16]             = w_pf_valid;
    w_stat[17]             = i_fifo_empty;
    w_stat[31:24]          = r_underrun;
  end

  // Read mux decodes the raw address so data is on the bus as soon as nOE falls.
  always_comb begin
    case (i_fmc_addr[3:0])
      ADDR_CTRL: o_rd_data = {29'd0, r_irq_en, 1'b0, r_stream_en};
      ADDR_STAT: o_rd_data = w_stat;
      ADDR_THR:  o_rd_data = {{(31-FIFO_AW){1'b0}}, r_thr};
      ADDR_DATA: o_rd_data = w_pf_valid ? r_pf_data : NO_DATA;
      default:   o_rd_data = NO_DATA;
    endcase
  end

  assign o_stream_en = r_stream_en;
  assign o_irq       = r_irq;
  assign w_unused    = ^{i_fmc_addr[15:4], r_wdata[31:FIFO_AW+1]};

endmodule

// File: tb/tb_fmc_stream_ctrl.sv
// Bench for fmc_stream_ctrl: queue-based FIFO and register model, per-cycle output compare,
// and directed FMC bus transactions with literal expectations.
module tb_fmc_stream_ctrl;
  localparam int AW = 10;
  localparam logic [3:0] A_CTRL = 4'h4;
  localparam logic [3:0] A_STAT = 4'h5;
  localparam logic [3:0] A_THR  = 4'h6;
  localparam logic [3:0] A_DATA = 4'h8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   fmc_addr = 16'h0000;
  logic [31:0]   fmc_data = 32'h0;
  logic          fmc_ne = 1'b1;
  logic          fmc_noe = 1'b1;
  logic          fmc_nwe = 1'b1;
  logic [31:0]   rd_data;
  logic [31:0]   fifo_dout = 32'h0;
  logic          fifo_empty = 1'b1;
  logic [AW-1:0] fifo_usedw = '0;
  logic          fifo_rd_en;
  logic          fifo_sclr;
  logic          stream_en;
  logic          irq;

  int n_vec = 0;
  int n_bad = 0;
  int pop_cnt = 0;
  int sclr_cnt = 0;
  bit chk_en = 1'b0;

  logic [31:0] q[$];
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];
  logic        m_stream_en = 1'b0;
  logic        m_irq_en = 1'b0;
  logic [AW:0] m_thr = '0;
  int          m_und = 0;
  logic        m_irq_q = 1'b0;

  always #5 clk = ~clk;

  fmc_stream_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_fmc_addr(fmc_addr), .i_fmc_data_in(fmc_data),
    .i_fmc_ne(fmc_ne), .i_fmc_noe(fmc_noe), .i_fmc_nwe(fmc_nwe), .o_rd_data(rd_data),
    .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty), .i_fifo_usedw(fifo_usedw),
    .o_fifo_rd_en(fifo_rd_en), .o_fifo_sclr(fifo_sclr), .o_stream_en(stream_en), .o_irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Sample FIFO: standard mode, 1-cycle read latency, synchronous clear.
  always @(posedge clk) begin
    if (fifo_sclr) begin
      q.delete();
      sclr_cnt <= sclr_cnt + 1;
    end else if (fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (q.size() > 0) fifo_dout <= q.pop_front();
    end
    while (pend.size() > 0) q.push_back(pend.pop_front());
    fifo_empty <= (q.size() == 0);
    fifo_usedw <= AW'(q.size());
  end

  // Model of the registered irq level.
  always @(posedge clk) begin
    if (reset) m_irq_q <= 1'b0;
    else       m_irq_q <= m_irq_en && ({1'b0, fifo_usedw} >= m_thr);
  end

  // Per-cycle compare while no bus transaction is settling.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("irq", {31'd0, irq}, {31'd0, m_irq_q});
      chk("stream_en", {31'd0, stream_en}, {31'd0, m_stream_en});
      chk("sclr_idle", {31'd0, fifo_sclr}, 32'd0);
      if (!m_stream_en) chk("rd_en_off", {31'd0, fifo_rd_en}, 32'd0);
    end
  end

  task automatic push_word(input logic [31:0] d);
    pend.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    chk_en = 1'b0;
    @(negedge clk);
    fmc_addr = {12'h000, a}; fmc_data = d; fmc_ne = 1'b0; fmc_nwe = 1'b0;
    repeat (4) @(negedge clk);
    fmc_nwe = 1'b1; fmc_ne = 1'b1;
    repeat (5) @(negedge clk);
    if (a == A_CTRL) begin
      m_stream_en = d[0];
      m_irq_en = d[2];
      if (d[1]) begin
        exp_q.delete();
        m_und = 0;
      end
    end
    if (a == A_THR) m_thr = d[AW:0];
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, input bit reset_on_fetch, output logic [31:0] got);
    logic [31:0] ev;
    bit seen;
    chk_en = 1'b0;
    ev = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
    @(negedge clk);
    fmc_addr = {12'h000, a}; fmc_ne = 1'b0; fmc_noe = 1'b0;
    got = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = rd_data;
      chk("no_pop_in_strobe", {31'd0, fifo_rd_en}, 32'd0);
      if (a == A_DATA) chk("data_window", got, ev);
    end
    fmc_noe = 1'b1; fmc_ne = 1'b1;
    if (a == A_DATA) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (m_und < 255) m_und++;
    end
    if (reset_on_fetch) begin
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        @(negedge clk);
        seen = fifo_rd_en;
      end
      chk("refetch_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      repeat (6) @(negedge clk);
      chk_en = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    chk_en = 1'b0;
    reset = 1'b1;
    repeat (n) @(negedge clk);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_sclr", {31'd0, fifo_sclr}, 32'd0);
    chk("rst_stream_en", {31'd0, stream_en}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    m_stream_en = 1'b0; m_irq_en = 1'b0; m_thr = '0; m_und = 0;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] w[0:16];
    int p0;
    for (int i = 0; i < 17; i++) w[i] = 32'h5700_0000 + 32'(i);

    do_reset(3);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_reset", got, 32'h0002_0000);
    chk("irq_reset", {31'd0, irq}, 32'd0);
    chk("pops_reset", 32'(pop_cnt), 32'd0);

    // Three words queued while streaming is off: nothing must be fetched.
    push_word(32'hA1A1_0001); push_word(32'hB2B2_0002); push_word(32'hC3C3_0003);
    repeat (4) @(negedge clk);
    chk("pops_disabled", 32'(pop_cnt), 32'd0);
    bus_write(A_CTRL, 32'h1);
    chk("pops_prefetch", 32'(pop_cnt), 32'd1);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_prefetch", got, 32'h0001_0002);
    bus_read(A_DATA, 1'b0, got);
    chk("word_a", got, 32'hA1A1_0001);
    chk("pops_after_a", 32'(pop_cnt), 32'd2);
    bus_read(A_DATA, 1'b0, got);
    chk("word_b", got, 32'hB2B2_0002);
    chk("pops_after_b", 32'(pop_cnt), 32'd3);
    bus_read(A_DATA, 1'b0, got);
    chk("word_c", got, 32'hC3C3_0003);
    chk("pops_after_c", 32'(pop_cnt), 32'd3);

    // Underrun counting and saturation.
    bus_read(A_STAT, 1'b0, got);
    chk("stat_drained", got, 32'h0002_0000);
    bus_read(A_DATA, 1'b0, got);
    chk("underrun_word", got, 32'hDEAD_BEEF);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_und1", got, 32'h0102_0000);
    for (int i = 0; i < 299; i++) bus_read(A_DATA, 1'b0, got);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_und_sat", got, 32'hFF02_0000);
    chk("und_model", {24'd0, got[31:24]}, 32'(m_und));
    chk("pops_underrun", 32'(pop_cnt), 32'd3);

    // Flush with prefetch full and a word still in the FIFO.
    push_word(32'hD4D4_0004); push_word(32'hE5E5_0005);
    repeat (6) @(negedge clk);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_pre_flush", got, 32'hFF01_0001);
    bus_write(A_CTRL, 32'h3);
    chk("sclr_once", 32'(sclr_cnt), 32'd1);
    bus_read(A_STAT, 1'b0, got);
    chk("stat_flushed", got, 32'h0002_0000);
    bus_read(A_CTRL, 1'b0, got);
    chk("ctrl_readback", got, 32'h0000_0001);
    push_word(32'hF6F6_0006);
    repeat (6) @(negedge clk);
    bus_read(A_DATA, 1'b0, got);
    chk("word_after_flush", got, 32'hF6F6_0006);

    // Threshold interrupt.
    bus_write(A_THR, 32'd16);
    bus_read(A_THR, 1'b0, got);
    chk("thr_readback", got, 32'h0000_0010);
    bus_write(A_CTRL, 32'h5);
    for (int i = 0; i < 16; i++) push_word(w[i]);
    repeat (8) @(negedge clk);
    chk("irq_at_15", {31'd0, irq}, 32'd0);
    push_word(w[16]);
    @(negedge clk);
    chk("irq_edge_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_at_16", {31'd0, irq}, 32'd1);
    bus_read(A_DATA, 1'b0, got);
    chk("word_w0", got, w[0]);
    repeat (2) @(negedge clk);
    chk("irq_back_15", {31'd0, irq}, 32'd0);

    // Reset while a refetch is in flight: the fetched word is lost, not re-delivered.
    p0 = pop_cnt;
    bus_read(A_DATA, 1'b1, got);
    chk("word_w1", got, w[1]);
    do_reset(2);
    chk("pops_fetch_rst", 32'(pop_cnt), 32'(p0 + 1));
    bus_read(A_STAT, 1'b0, got);
    chk("stat_after_rst", got, 32'h0000_000E);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_DATA, 1'b0, got);
    chk("word_w3", got, w[3]);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
